// File: rtl/cam_downscale_2x2.sv
// rtl/cam_downscale_2x2.sv - 2x2 box-filter decimator for the RGB444 capture write stream
module cam_downscale_2x2 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_wren,
  input  logic [18:0] i_pix_addr,
  input  logic [11:0] i_pix_data,
  output logic        o_wren,
  output logic [16:0] o_pix_addr,
  output logic [11:0] o_pix_data,
  output logic        o_frame_done
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int LAW = XW - 1;
  localparam int LBW = IMG_W / 2;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [16:0]   HALF_W = 17'(IMG_W / 2);

  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [11:0]    r_hold;
  logic [14:0]    r_lbuf [LBW];
  logic [14:0]    r_lb_q;
  logic           r_s1_valid;
  logic [14:0]    r_s1_hsum;
  logic [16:0]    r_s1_addr;
  logic           r_s1_last;

  logic           w_sof;
  logic [XW-1:0]  w_x;
  logic [YW-1:0]  w_y;
  logic [LAW-1:0] w_lb_addr;
  logic [4:0]     w_h_r;
  logic [4:0]     w_h_g;
  logic [4:0]     w_h_b;
  logic [14:0]    w_hsum;
  logic [16:0]    w_out_addr;
  logic [5:0]     w_sum_r;
  logic [5:0]     w_sum_g;
  logic [5:0]     w_sum_b;

  // A write to address 0 always restarts the frame at (0,0), whatever the counters say.
  assign w_sof      = (i_pix_addr == 19'd0);
  assign w_x        = w_sof ? '0 : r_x;
  assign w_y        = w_sof ? '0 : r_y;
  assign w_lb_addr  = w_x[XW-1:1];

  assign w_h_r      = {1'b0, r_hold[11:8]} + {1'b0, i_pix_data[11:8]};
  assign w_h_g      = {1'b0, r_hold[7:4]}  + {1'b0, i_pix_data[7:4]};
  assign w_h_b      = {1'b0, r_hold[3:0]}  + {1'b0, i_pix_data[3:0]};
  assign w_hsum     = {w_h_r, w_h_g, w_h_b};
  assign w_out_addr = 17'(w_y[YW-1:1]) * HALF_W + 17'(w_lb_addr);

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_hold <= '0;
    end else if (i_wren) begin
      if (w_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_y == Y_LAST) ? '0 : w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
      if (!w_x[0]) begin
        r_hold <= i_pix_data;
      end
    end
  end

  // Even rows deposit horizontal pair sums; odd rows read them back one cycle later.
  always_ff @(posedge i_pclk) begin
    if (i_wren) begin
      if (w_x[0] && !w_y[0]) begin
        r_lbuf[w_lb_addr] <= w_hsum;
      end
      r_lb_q <= r_lbuf[w_lb_addr];
    end
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_hsum  <= '0;
      r_s1_addr  <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= i_wren & w_x[0] & w_y[0];
      if (i_wren && w_x[0]) begin
        r_s1_hsum <= w_hsum;
        r_s1_addr <= w_out_addr;
        r_s1_last <= (w_x == X_LAST) && (w_y == Y_LAST);
      end
    end
  end

  assign w_sum_r = {1'b0, r_lb_q[14:10]} + {1'b0, r_s1_hsum[14:10]};
  assign w_sum_g = {1'b0, r_lb_q[9:5]}   + {1'b0, r_s1_hsum[9:5]};
  assign w_sum_b = {1'b0, r_lb_q[4:0]}   + {1'b0, r_s1_hsum[4:0]};

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      o_wren       <= 1'b0;
      o_pix_addr   <= '0;
      o_pix_data   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_wren       <= r_s1_valid;
      o_frame_done <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        o_pix_addr <= r_s1_addr;
        o_pix_data <= {w_sum_r[5:2], w_sum_g[5:2], w_sum_b[5:2]};
      end
    end
  end

endmodule

// File: tb/tb_cam_downscale_2x2.sv
// tb/tb_cam_downscale_2x2.sv - directed checks of cam_downscale_2x2 on a 16x8 frame
module tb_cam_downscale_2x2;
  localparam int W    = 16;
  localparam int H    = 8;
  localparam int NOUT = (W / 2) * (H / 2);

  logic        i_pclk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wren = 1'b0;
  logic [18:0] i_pix_addr = '0;
  logic [11:0] i_pix_data = '0;
  logic        o_wren;
  logic [16:0] o_pix_addr;
  logic [11:0] o_pix_data;
  logic        o_frame_done;

  typedef struct packed {
    logic [16:0] a;
    logic [11:0] d;
    logic        fd;
  } ent_t;

  ent_t q[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   n_fd_stray = 0;

  always #5 i_pclk = ~i_pclk;

  cam_downscale_2x2 #(.IMG_W(W), .IMG_H(H)) dut (
    .i_pclk      (i_pclk),
    .i_rst       (i_rst),
    .i_wren      (i_wren),
    .i_pix_addr  (i_pix_addr),
    .i_pix_data  (i_pix_data),
    .o_wren      (o_wren),
    .o_pix_addr  (o_pix_addr),
    .o_pix_data  (o_pix_data),
    .o_frame_done(o_frame_done)
  );

  always @(negedge i_pclk) begin
    if (!i_rst) begin
      if (o_wren) q.push_back({o_pix_addr, o_pix_data, o_frame_done});
      else if (o_frame_done) n_fd_stray++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Uniform A5C, with a hand-picked averaging block at the origin and a truncation block at the last corner.
  function automatic logic [11:0] pix(input int x, input int y);
    if (x == 0 && y == 0) return 12'hF00;
    if (x == 1 && y == 0) return 12'h0F0;
    if (x == 0 && y == 1) return 12'h00F;
    if (x == 1 && y == 1) return 12'hFFF;
    if (x == W - 1 && y == H - 1) return 12'h0E0;
    if (x >= W - 2 && y >= H - 2) return 12'h1F0;
    return 12'hA5C;
  endfunction

  task automatic drive(input logic [18:0] a, input logic [11:0] d, input int gap);
    @(negedge i_pclk);
    i_wren = 1'b1;
    i_pix_addr = a;
    i_pix_data = d;
    for (int g = 0; g < gap; g++) begin
      @(negedge i_pclk);
      i_wren = 1'b0;
    end
  endtask

  task automatic send_frame(input int gap, input int base, input bit lat);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (lat && x == 1 && y == 1) begin
          drive(19'(base + y * W + x), pix(x, y), 0);
          @(negedge i_pclk);
          i_wren = 1'b0;
          check("lat_c1_wren", 32'(o_wren), 32'd0);
          @(negedge i_pclk);
          check("lat_c2_wren", 32'(o_wren), 32'd1);
          check("lat_c2_addr", 32'(o_pix_addr), 32'd0);
          check("lat_c2_data", 32'(o_pix_data), 32'h777);
          @(negedge i_pclk);
          check("lat_c3_wren", 32'(o_wren), 32'd0);
        end else begin
          drive(19'(base + y * W + x), pix(x, y), gap);
        end
      end
    end
    @(negedge i_pclk);
    i_wren = 1'b0;
    repeat (4) @(negedge i_pclk);
  endtask

  task automatic check_frame(input string tag);
    logic [11:0] ed;
    check({tag, "_count"}, 32'(q.size()), 32'(NOUT));
    for (int i = 0; i < q.size() && i < NOUT; i++) begin
      ed = (i == 0) ? 12'h777 : (i == NOUT - 1) ? 12'h0E0 : 12'hA5C;
      check({tag, "_addr"}, 32'(q[i].a), 32'(i));
      check({tag, "_data"}, 32'(q[i].d), 32'(ed));
      check({tag, "_fdone"}, 32'(q[i].fd), 32'(i == NOUT - 1));
    end
  endtask

  initial begin
    repeat (3) @(negedge i_pclk);
    check("rst_wren", 32'(o_wren), 32'd0);
    check("rst_addr", 32'(o_pix_addr), 32'd0);
    check("rst_data", 32'(o_pix_data), 32'd0);
    check("rst_fdone", 32'(o_frame_done), 32'd0);
    i_rst = 1'b0;

    q.delete();
    send_frame(1, 0, 1'b1);
    check_frame("gap1");

    q.delete();
    send_frame(0, 0, 1'b0);
    check_frame("b2b");

    // Partial frame leaves the counters mid-frame; the following addr-0 write must resync.
    q.delete();
    for (int k = 0; k < 40; k++) drive(19'(500 + k), 12'h000, 1);
    @(negedge i_pclk);
    i_wren = 1'b0;
    repeat (4) @(negedge i_pclk);
    check("part_count", 32'(q.size()), 32'd8);
    for (int i = 0; i < q.size() && i < 8; i++) begin
      check("part_addr", 32'(q[i].a), 32'(i));
      check("part_data", 32'(q[i].d), 32'd0);
    end
    q.delete();
    send_frame(1, 0, 1'b0);
    check_frame("resync");

    // Reset lands while the (1,1) output is in flight; it must be dropped.
    q.delete();
    for (int k = 0; k < W + 1; k++) drive(19'(2000 + k), pix(k % W, k / W), 1);
    @(negedge i_pclk);
    i_wren = 1'b1;
    i_pix_addr = 19'(2000 + W + 1);
    i_pix_data = pix(1, 1);
    @(posedge i_pclk);
    #2;
    check("pre_rst_addr", 32'(o_pix_addr), 32'(NOUT - 1));
    i_rst = 1'b1;
    #1;
    check("async_rst_wren", 32'(o_wren), 32'd0);
    check("async_rst_addr", 32'(o_pix_addr), 32'd0);
    check("async_rst_data", 32'(o_pix_data), 32'd0);
    check("async_rst_fdone", 32'(o_frame_done), 32'd0);
    i_wren = 1'b0;
    repeat (3) @(negedge i_pclk);
    i_rst = 1'b0;
    repeat (6) @(negedge i_pclk);
    check("rst_drop_count", 32'(q.size()), 32'd0);

    q.delete();
    send_frame(1, 1000, 1'b0);
    check_frame("post_rst");

    check("fdone_stray", 32'(n_fd_stray), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
